// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the 256-point FFT datapath.
package fft_pkg;

  localparam int N_POINTS   = 256;
  localparam int LOG2N      = 8;
  localparam int TOTAL_BITS = 30;
  localparam int OUT_BITS   = 20;
  localparam int FRAC_SHIFT = 2;

  typedef logic signed [TOTAL_BITS-1:0] sample_t;
  typedef logic signed [OUT_BITS-1:0]   out_sample_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_t;

  function automatic logic [LOG2N-1:0] bitrev8(
    input logic [LOG2N-1:0] a
  );
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++)
      r[i] = a[LOG2N-1-i];
    return r;
  endfunction

endpackage

// File: rtl/out_quantizer.sv
// Round-half-up, arithmetic shift and saturate one datapath word
// to the external sample width.
module out_quantizer
  import fft_pkg::*;
(
  input  sample_t     x,
  output out_sample_t y,
  output logic        ovf
);

  localparam int W = TOTAL_BITS + 1;

  localparam logic signed [W-1:0] HALF =
    W'(2 ** (FRAC_SHIFT - 1));
  localparam logic signed [W-1:0] MAXV =
    W'(2 ** (OUT_BITS - 1) - 1);
  localparam logic signed [W-1:0] MINV =
    W'(-(2 ** (OUT_BITS - 1)));

  logic signed [W-1:0] sum;
  logic signed [W-1:0] sh;

  always_comb begin
    sum = W'(x) + HALF;
    sh  = sum >>> FRAC_SHIFT;
    ovf = 1'b0;
    y   = sh[OUT_BITS-1:0];
    if (sh > MAXV) begin
      y   = MAXV[OUT_BITS-1:0];
      ovf = 1'b1;
    end else if (sh < MINV) begin
      y   = MINV[OUT_BITS-1:0];
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/output_serializer.sv
// Frame capture and valid/ready streaming of FFT results.
// Define OUTPUT_SERIALIZER_BITREV_EN for bit-reversed bin order.
module output_serializer
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  sample_t          realin [N_POINTS],
  input  sample_t          imagin [N_POINTS],
  input  logic             out_ready,
  output logic             out_valid,
  output out_sample_t      realout,
  output out_sample_t      imagout,
  output logic [LOG2N-1:0] out_index,
  output logic             out_last,
  output logic             busy,
  output logic             sat_flag,
  output logic             load_drop
);

  localparam logic [LOG2N-1:0] LAST_IDX =
    LOG2N'(N_POINTS - 1);

  ser_state_t       state;
  sample_t          re_mem [N_POINTS];
  sample_t          im_mem [N_POINTS];
  logic [LOG2N-1:0] count;
  logic [LOG2N-1:0] count_nxt;
  logic [LOG2N-1:0] addr;
  logic             xfer;
  logic             last_xfer;
  logic             accept;
  logic             advance;
  sample_t          re_src;
  sample_t          im_src;
  out_sample_t      re_q;
  out_sample_t      im_q;
  logic             re_ovf;
  logic             im_ovf;

  assign xfer      = out_valid & out_ready;
  assign last_xfer = xfer & out_last;
  assign accept    = load & ((state == IDLE) | last_xfer);
  assign advance   = xfer & ~out_last;
  assign count_nxt = accept ? '0 : count + LOG2N'(1);

`ifdef OUTPUT_SERIALIZER_BITREV_EN
  assign addr = bitrev8(count_nxt);
`else
  assign addr = count_nxt;
`endif

  // First sample of a new frame bypasses the frame registers
  assign re_src = accept ? realin[addr] : re_mem[addr];
  assign im_src = accept ? imagin[addr] : im_mem[addr];

  out_quantizer u_q_re (
    .x   (re_src),
    .y   (re_q),
    .ovf (re_ovf)
  );

  out_quantizer u_q_im (
    .x   (im_src),
    .y   (im_q),
    .ovf (im_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_POINTS; i++) begin
        re_mem[i] <= '0;
        im_mem[i] <= '0;
      end
    end else if (accept) begin
      re_mem <= realin;
      im_mem <= imagin;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      realout   <= '0;
      imagout   <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
      load_drop <= 1'b0;
    end else begin
      if (accept | advance) begin
        state     <= STREAM;
        count     <= count_nxt;
        out_valid <= 1'b1;
        busy      <= 1'b1;
        realout   <= re_q;
        imagout   <= im_q;
        out_index <= addr;
        out_last  <= (count_nxt == LAST_IDX);
        sat_flag  <= (sat_flag & ~accept)
                   | re_ovf | im_ovf;
      end else if (last_xfer) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        busy      <= 1'b0;
        out_last  <= 1'b0;
      end
      if (load & ~accept & (state == STREAM))
        load_drop <= 1'b1;
    end
  end

endmodule
